// File: rtl/tt_clock_pkg.sv
// Shared types and constants for the binary clock input-conditioning stage.
// Button FSM states, arbitration indices, default timing and a counter-width helper.
package tt_clock_pkg;

    typedef enum logic [1:0] {StIdle, StPress, StRepeat} btn_state_e;

    // Lower index wins arbitration.
    localparam int unsigned SEC    = 0;
    localparam int unsigned MIN    = 1;
    localparam int unsigned HOUR   = 2;
    localparam int unsigned NumBtn = 3;

    localparam int unsigned DefClkHz          = 100;
    localparam int unsigned DefDebounceCycles = 5;
    localparam int unsigned DefRepeatDelay    = 50;
    localparam int unsigned DefRepeatPeriod   = 20;

    // Bits needed for a counter holding 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tt_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
// The level flips only after DEBOUNCE_CYCLES synchronized samples all disagree with it.
module tt_debounce
    import tt_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned        CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]    CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/tt_clock_input_ctrl.sv
// Input conditioning for the binary clock: debounced switches, arbitrated step pulses with
// hold-to-repeat, and the 1 Hz tick prescaler that runs only outside set mode.
module tt_clock_input_ctrl
    import tt_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DefClkHz,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic time_set_raw,
    input  logic id_switch_raw,
    input  logic hour_btn_raw,
    input  logic minute_btn_raw,
    input  logic seconds_btn_raw,
    output logic set_mode,
    output logic inc_dec,
    output logic hour_step,
    output logic minute_step,
    output logic seconds_step,
    output logic tick_1hz
);

    localparam int unsigned     RepMax     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                            : REPEAT_PERIOD;
    localparam int unsigned     RepW       = cnt_width(RepMax);
    localparam logic [RepW-1:0] DelayLoad  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PeriodLoad = RepW'(REPEAT_PERIOD - 1);
    localparam int unsigned     PreW       = cnt_width(CLK_HZ);
    localparam logic [PreW-1:0] PreMax     = PreW'(CLK_HZ - 1);

    logic [NumBtn-1:0] btn_lvl;

    tt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_i   (time_set_raw),
        .level_o (set_mode)
    );

    tt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dir (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_i   (id_switch_raw),
        .level_o (inc_dec)
    );

    tt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hour (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_i   (hour_btn_raw),
        .level_o (btn_lvl[HOUR])
    );

    tt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_min (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_i   (minute_btn_raw),
        .level_o (btn_lvl[MIN])
    );

    tt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sec (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_i   (seconds_btn_raw),
        .level_o (btn_lvl[SEC])
    );

    btn_state_e        state_q [NumBtn];
    btn_state_e        state_d [NumBtn];
    logic [RepW-1:0]   rep_q   [NumBtn];
    logic [RepW-1:0]   rep_d   [NumBtn];
    logic [NumBtn-1:0] want, grant;
    logic [NumBtn-1:0] step_q;
    logic [PreW-1:0]   pre_q, pre_d;

    // Counters load one less than the interval so expiry is a compare against zero.
    always_comb begin
        want = '0;
        for (int b = 0; b < NumBtn; b++) begin
            state_d[b] = state_q[b];
            rep_d[b]   = rep_q[b];
            if (!(set_mode && btn_lvl[b])) begin
                state_d[b] = StIdle;
                rep_d[b]   = '0;
            end else begin
                case (state_q[b])
                    StIdle: begin
                        want[b]    = 1'b1;
                        rep_d[b]   = DelayLoad;
                        state_d[b] = StPress;
                    end
                    StPress, StRepeat: begin
                        if (rep_q[b] == '0) begin
                            want[b]    = 1'b1;
                            rep_d[b]   = PeriodLoad;
                            state_d[b] = StRepeat;
                        end else begin
                            rep_d[b] = rep_q[b] - RepW'(1);
                        end
                    end
                    default: state_d[b] = StIdle;
                endcase
            end
        end
    end

    // Losers are dropped outright; their counters have already reloaded above.
    always_comb begin
        grant = '0;
        if (want[SEC]) begin
            grant[SEC] = 1'b1;
        end else if (want[MIN]) begin
            grant[MIN] = 1'b1;
        end else if (want[HOUR]) begin
            grant[HOUR] = 1'b1;
        end
    end

    always_comb begin
        if (set_mode || pre_q == PreMax) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PreW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < NumBtn; b++) begin
                state_q[b] <= StIdle;
                rep_q[b]   <= '0;
            end
            step_q <= '0;
            pre_q  <= '0;
        end else begin
            for (int b = 0; b < NumBtn; b++) begin
                state_q[b] <= state_d[b];
                rep_q[b]   <= rep_d[b];
            end
            step_q <= grant;
            pre_q  <= pre_d;
        end
    end

    assign seconds_step = step_q[SEC];
    assign minute_step  = step_q[MIN];
    assign hour_step    = step_q[HOUR];
    assign tick_1hz     = ~set_mode & (pre_q == PreMax);

endmodule

// File: tb/tb_tt_clock_input_ctrl.sv
// Bench for tt_clock_input_ctrl: directed scenarios plus random switch/button activity,
// every cycle compared against a history-window / elapsed-time reference model.
module tb_tt_clock_input_ctrl;

    localparam int ClkHz     = 100;
    localparam int Deb       = 5;
    localparam int RepDelay  = 50;
    localparam int RepPeriod = 20;

    logic       clk = 1'b0;
    logic       reset_i;
    // raw[0]=time_set, [1]=id_switch, [2]=hour, [3]=minute, [4]=seconds
    logic [4:0] raw;
    logic       set_mode, inc_dec, hour_step, minute_step, seconds_step, tick_1hz;

    always #5 clk = ~clk;

    tt_clock_input_ctrl dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .time_set_raw    (raw[0]),
        .id_switch_raw   (raw[1]),
        .hour_btn_raw    (raw[2]),
        .minute_btn_raw  (raw[3]),
        .seconds_btn_raw (raw[4]),
        .set_mode        (set_mode),
        .inc_dec         (inc_dec),
        .hour_step       (hour_step),
        .minute_step     (minute_step),
        .seconds_step    (seconds_step),
        .tick_1hz        (tick_1hz)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Model state: raw history per input (bit j = raw value j edges ago), debounced levels,
    // per-button press start time (model index 0=sec,1=min,2=hour), tick count.
    bit [Deb+1:0] hist [5];
    bit [4:0]     m_lvl;
    bit           m_active [3];
    int           m_t0 [3];
    bit [2:0]     m_step;
    int           m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) hist[i] = '0;
        m_lvl  = '0;
        m_step = '0;
        m_cnt  = 0;
        for (int b = 0; b < 3; b++) begin
            m_active[b] = 1'b0;
            m_t0[b]     = 0;
        end
    endtask

    task automatic model_edge();
        bit       sm;
        bit [4:0] lvl_pre;
        bit [2:0] want;
        bit       all_diff;
        int       d;
        if (reset_i) begin
            model_clear();
            return;
        end
        sm      = m_lvl[0];
        lvl_pre = m_lvl;
        // Level flips once the last Deb synchronized samples (raw delayed 2) all disagree.
        for (int i = 0; i < 5; i++) begin
            hist[i]  = {hist[i][Deb:0], raw[i]};
            all_diff = 1'b1;
            for (int j = 0; j < Deb; j++) if (hist[i][2+j] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) m_lvl[i] = ~m_lvl[i];
        end
        want = '0;
        for (int b = 0; b < 3; b++) begin
            if (!(sm && lvl_pre[4-b])) begin
                m_active[b] = 1'b0;
            end else if (!m_active[b]) begin
                m_active[b] = 1'b1;
                m_t0[b]     = edge_n;
                want[b]     = 1'b1;
            end else begin
                d       = edge_n - m_t0[b];
                want[b] = (d == RepDelay) ||
                          (d > RepDelay && ((d - RepDelay) % RepPeriod) == 0);
            end
        end
        m_step = '0;
        if (want[0])      m_step[0] = 1'b1;
        else if (want[1]) m_step[1] = 1'b1;
        else if (want[2]) m_step[2] = 1'b1;
        m_cnt = sm ? 0 : (m_cnt + 1) % ClkHz;
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        check_eq("set_mode", set_mode, m_lvl[0]);
        check_eq("inc_dec", inc_dec, m_lvl[1]);
        check_eq("seconds_step", seconds_step, m_step[0]);
        check_eq("minute_step", minute_step, m_step[1]);
        check_eq("hour_step", hour_step, m_step[2]);
        check_eq("tick_1hz", tick_1hz, (m_cnt == ClkHz - 1) && !m_lvl[0]);
        check_eq("step_onehot", 32'($countones({hour_step, minute_step, seconds_step}) <= 1), 1);
    endtask

    int rel, t, first, f, cnt_a, cnt_b, tick_at;
    int pulses[$];
    int exp_off[5] = '{0, 50, 70, 90, 110};

    initial begin
        model_clear();
        reset_i = 1'b1;
        raw     = '1;

        // Reset with everything high; then debounced levels appear 7 edges after release.
        repeat (3) begin
            cycle();
            check_eq("reset_outputs",
                     {set_mode, inc_dec, hour_step, minute_step, seconds_step, tick_1hz}, 0);
        end
        reset_i = 1'b0;
        rel     = edge_n;
        first   = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i == 0)
                check_eq("post_reset_outputs",
                         {set_mode, inc_dec, hour_step, minute_step, seconds_step, tick_1hz}, 0);
            if (set_mode && first < 0) first = edge_n - rel;
        end
        check_eq("debounce_latency", first, 7);

        // Free-running tick.
        raw     = '0;
        reset_i = 1'b1;
        cycle();
        cycle();
        reset_i = 1'b0;
        rel     = edge_n;
        cnt_a   = 0;
        for (int i = 0; i < 350; i++) begin
            cycle();
            if (tick_1hz) begin
                cnt_a++;
                check_eq("tick_position", (edge_n - rel) % ClkHz, ClkHz - 1);
            end
        end
        check_eq("tick_count_350", cnt_a, 3);

        // Glitch then stable press on minute in set mode.
        raw[0] = 1'b1;
        repeat (15) cycle();
        raw[3] = 1'b1;
        repeat (3) cycle();
        raw[3] = 1'b0;
        cnt_a  = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (minute_step) cnt_a++;
        end
        check_eq("glitch_no_pulse", cnt_a, 0);
        raw[3] = 1'b1;
        t      = edge_n;
        first  = -1;
        cnt_a  = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (minute_step) begin
                cnt_a++;
                if (first < 0) first = edge_n - t;
            end
        end
        check_eq("minute_latency", first, 8);
        check_eq("minute_single", cnt_a, 1);
        raw[3] = 1'b0;
        repeat (20) cycle();

        // Hold-to-repeat on hour.
        raw[2] = 1'b1;
        t      = edge_n;
        pulses.delete();
        for (int i = 0; i < 160; i++) begin
            if (i == 120) raw[2] = 1'b0;
            cycle();
            if (hour_step) pulses.push_back(edge_n - t);
        end
        check_eq("repeat_count", pulses.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq("repeat_time", (i < pulses.size()) ? pulses[i] : -1, 8 + exp_off[i]);

        // Seconds beats hour when both pressed together.
        raw[4] = 1'b1;
        raw[2] = 1'b1;
        cnt_a  = 0;
        cnt_b  = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (seconds_step) cnt_a++;
            if (hour_step) cnt_b++;
        end
        check_eq("prio_seconds_pulses", cnt_a, 3);
        check_eq("prio_hour_suppressed", cnt_b, 0);
        raw[4] = 1'b0;
        raw[2] = 1'b0;
        repeat (30) cycle();

        // Leave set mode while holding minute.
        raw[3] = 1'b1;
        repeat (30) cycle();
        raw[0]  = 1'b0;
        f       = -1;
        tick_at = -1;
        cnt_a   = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!set_mode && f < 0) f = edge_n;
            if (f >= 0 && (minute_step || seconds_step || hour_step)) cnt_a++;
            if (tick_1hz && tick_at < 0) tick_at = edge_n;
        end
        check_eq("exit_no_steps", cnt_a, 0);
        check_eq("exit_fall_seen", f >= 0, 1);
        // Tick is high after edge f+99, so the core consumes it on edge f+100.
        check_eq("exit_first_tick", tick_at - f + 1, ClkHz);
        raw[3] = 1'b0;
        repeat (10) cycle();

        // Random activity, with occasional mid-run reset.
        raw = 5'b00001;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) raw[0] = ~raw[0];
            if ($urandom_range(0, 99) == 0) raw[1] = ~raw[1];
            for (int k = 2; k < 5; k++)
                if ($urandom_range(0, 39) == 0) raw[k] = ~raw[k];
            reset_i = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        reset_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
